// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions, ExcCodes and
// the sequencer state encoding.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam int SR_IM_LO     = 10;
    localparam int SR_IM_HI     = 15;
    localparam int SR_EXL_BIT   = 1;
    localparam int SR_IE_BIT    = 0;
    localparam int CAUSE_BD_BIT = 31;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTER,
        ST_HANDLER,
        ST_RETURN
    } cp0_state_t;

endpackage

// File: rtl/cp0_exc_ctrl_epc_align.sv
// Word-aligns the faulting PC and backs it up one instruction when the
// instruction sits in a branch delay slot (wraps modulo 2^32).
module epc_align (
    input  logic [31:0] pc,
    input  logic        bd,
    output logic [31:0] epc
);

    logic [31:0] aligned;

    assign aligned = pc & 32'hFFFF_FFFC;
    assign epc     = bd ? (aligned - 32'd4) : aligned;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt sequencer at the M stage: owns SR/Cause/EPC/PRId and
// drives the one-cycle flush/redirect into the handler and back out on eret.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL   = 32'h4543_0001
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m_valid,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic        exc_req_m,
    input  logic [4:0]  exccode_m,
    input  logic        eret_m,
    input  logic [5:0]  hw_int,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        exl
);

    cp0_state_t  state;
    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;
    logic [31:0] epc_new;
    logic        exc_fire;
    logic        int_fire;
    logic        eret_fire;

    epc_align u_epc_align (
        .pc  (pc_m),
        .bd  (bd_m),
        .epc (epc_new)
    );

    assign exc_fire  = m_valid & exc_req_m;
    assign eret_fire = m_valid & eret_m;
    assign int_fire  = sr_ie & ~sr_exl & (|(cause_ip & sr_im)) & m_valid;
    assign exl       = sr_exl;

    // Nested exceptions (from HANDLER) keep the original EPC/BD so eret
    // still returns to the first faulting instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            sr_im          <= '0;
            sr_exl         <= 1'b0;
            sr_ie          <= 1'b0;
            cause_bd       <= 1'b0;
            cause_ip       <= '0;
            cause_exc      <= '0;
            epc            <= '0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            cause_ip       <= hw_int;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            unique case (state)
                ST_IDLE, ST_HANDLER: begin
                    if (exc_fire) begin
                        if (state == ST_IDLE) begin
                            epc      <= epc_new;
                            cause_bd <= bd_m;
                            sr_exl   <= 1'b1;
                        end
                        cause_exc      <= exccode_m;
                        state          <= ST_ENTER;
                        flush          <= 1'b1;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= HANDLER_PC;
                    end else if (int_fire && state == ST_IDLE) begin
                        epc            <= epc_new;
                        cause_bd       <= bd_m;
                        sr_exl         <= 1'b1;
                        cause_exc      <= EXC_INT;
                        state          <= ST_ENTER;
                        flush          <= 1'b1;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= HANDLER_PC;
                    end else if (eret_fire) begin
                        state          <= ST_RETURN;
                        flush          <= 1'b1;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= epc;
                    end else if (cp0_we) begin
                        if (cp0_addr == REG_SR) begin
                            sr_im  <= cp0_wdata[SR_IM_HI:SR_IM_LO];
                            sr_exl <= cp0_wdata[SR_EXL_BIT];
                            sr_ie  <= cp0_wdata[SR_IE_BIT];
                        end else if (cp0_addr == REG_EPC) begin
                            epc <= cp0_wdata;
                        end
                    end
                end
                ST_ENTER: begin
                    state <= ST_HANDLER;
                end
                ST_RETURN: begin
                    sr_exl <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            REG_SR: begin
                cp0_rdata[SR_IM_HI:SR_IM_LO] = sr_im;
                cp0_rdata[SR_EXL_BIT]        = sr_exl;
                cp0_rdata[SR_IE_BIT]         = sr_ie;
            end
            REG_CAUSE: begin
                cp0_rdata[CAUSE_BD_BIT]                = cause_bd;
                cp0_rdata[CAUSE_IP_HI:CAUSE_IP_LO]     = cause_ip;
                cp0_rdata[CAUSE_EXC_HI:CAUSE_EXC_LO]   = cause_exc;
            end
            REG_EPC:  cp0_rdata = epc;
            REG_PRID: cp0_rdata = PRID_VAL;
            default:  cp0_rdata = '0;
        endcase
    end

endmodule
